// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the in-order issue scoreboard: op classes, FSM states
// and small decode helpers used by the top and the busy-bit register file.
package issue_scoreboard_pkg;

  localparam logic [2:0] OT_INT    = 3'd0;
  localparam logic [2:0] OT_BRANCH = 3'd1;
  localparam logic [2:0] OT_LOAD   = 3'd2;
  localparam logic [2:0] OT_STORE  = 3'd3;
  localparam logic [2:0] OT_MULDIV = 3'd4;
  localparam logic [2:0] OT_CSR    = 3'd5;
  localparam logic [2:0] OT_FENCE  = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_POST  = 2'd2
  } state_e;

  function automatic logic is_long_op(input logic [2:0] op_type);
    return (op_type == OT_LOAD) || (op_type == OT_MULDIV);
  endfunction

  function automatic logic is_serial_op(input logic [2:0] op_type);
    return (op_type == OT_CSR) || (op_type == OT_FENCE);
  endfunction

  // x0 is hardwired, so its bit is always stripped from any mask.
  function automatic logic [31:0] reg_onehot(input logic en, input logic [4:0] idx);
    logic [31:0] m;
    m = '0;
    if (en) m[idx] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/issue_scoreboard_sb_regfile.sv
// 32-entry busy-bit file: one set port, two writeback clear ports, three
// read ports that see the same-cycle clears (writeback bypass).
module sb_regfile
  import issue_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en_i,
  input  logic [4:0] set_idx_i,
  input  logic       clr0_en_i,
  input  logic [4:0] clr0_idx_i,
  input  logic       clr1_en_i,
  input  logic [4:0] clr1_idx_i,
  input  logic [4:0] rs1_idx_i,
  input  logic [4:0] rs2_idx_i,
  input  logic [4:0] rd_idx_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o,
  output logic       rd_busy_o
);

  logic [31:0] busy_q, busy_d;
  logic [31:0] clr_mask, set_mask, eff_busy;

  always_comb begin
    clr_mask = reg_onehot(clr0_en_i, clr0_idx_i) | reg_onehot(clr1_en_i, clr1_idx_i);
    set_mask = reg_onehot(set_en_i, set_idx_i);
    eff_busy = busy_q & ~clr_mask;
    // Set applied after clear so a reissue to a retiring rd stays busy.
    busy_d   = eff_busy | set_mask;
  end

  assign rs1_busy_o = eff_busy[rs1_idx_i];
  assign rs2_busy_o = eff_busy[rs2_idx_i];
  assign rd_busy_o  = eff_busy[rd_idx_i];

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue control: stalls decode on RAW/WAW hazards against in-flight
// long ops and drains all outstanding long ops ahead of CSR/fence ops.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_flush,
  input  logic             dec_ix_valid,
  output logic             dec_ix_ready,
  input  logic [2:0]       dec_ix_op_type,
  input  logic             dec_ix_wb_en,
  input  logic             dec_ix_rs1_used,
  input  logic             dec_ix_rs2_used,
  input  logic [4:0]       dec_ix_rs1,
  input  logic [4:0]       dec_ix_rs2,
  input  logic [4:0]       dec_ix_rd,
  output logic             ix_issue_valid,
  input  logic             ix_issue_ready,
  input  logic             lsu_wb_valid,
  input  logic [4:0]       lsu_wb_rd,
  input  logic             md_wb_valid,
  input  logic [4:0]       md_wb_rd,
  output logic [CNT_W-1:0] sb_outstanding,
  output logic             sb_idle
);

  // Late writebacks (e.g. after reset) must not wrap the counter.
  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] diff;
    diff = {1'b0, a} - (CNT_W+1)'(b);
    return diff[CNT_W] ? '0 : diff[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] eff_out;
  logic [1:0]       wb_cnt;
  logic             rs1_busy, rs2_busy, rd_busy;
  logic             op_long, op_serial, hazard, can_issue, fire, set_en;

  assign op_long   = is_long_op(dec_ix_op_type);
  assign op_serial = is_serial_op(dec_ix_op_type);
  assign wb_cnt    = {1'b0, lsu_wb_valid} + {1'b0, md_wb_valid};
  assign eff_out   = sat_sub(out_q, wb_cnt);

  sb_regfile u_busy (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_idx_i  (dec_ix_rd),
    .clr0_en_i  (lsu_wb_valid),
    .clr0_idx_i (lsu_wb_rd),
    .clr1_en_i  (md_wb_valid),
    .clr1_idx_i (md_wb_rd),
    .rs1_idx_i  (dec_ix_rs1),
    .rs2_idx_i  (dec_ix_rs2),
    .rd_idx_i   (dec_ix_rd),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy)
  );

  always_comb begin
    hazard = (dec_ix_rs1_used & rs1_busy)
           | (dec_ix_rs2_used & rs2_busy)
           | (dec_ix_wb_en & (dec_ix_rd != 5'd0) & rd_busy)
           | (op_long & (eff_out == CNT_W'(MAX_OUTSTANDING)));
    can_issue = (state_q == ST_RUN) & ~hazard & (~op_serial | (eff_out == '0));
  end

  assign ix_issue_valid = ~rst & dec_ix_valid & can_issue & ~pipe_flush;
  assign dec_ix_ready   = ~rst & ix_issue_ready & (can_issue | ~dec_ix_valid);
  assign fire           = ix_issue_valid & ix_issue_ready;
  assign set_en         = fire & op_long & dec_ix_wb_en & (dec_ix_rd != 5'd0);
  assign out_d          = eff_out + CNT_W'(fire & op_long);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (fire && op_serial)
          state_d = ST_POST;
        else if (dec_ix_valid && op_serial && (eff_out != '0))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: if (eff_out == '0) state_d = ST_RUN;
      ST_POST:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    // A flushed op is gone, so there is nothing left to serialize.
    if (pipe_flush) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign sb_outstanding = out_q;
  assign sb_idle        = (out_q == '0) && (state_q == ST_RUN);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed scenarios plus a randomized run against a queue-based model of
// in-flight long ops for issue_scoreboard.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst, pipe_flush;
  logic          dec_ix_valid, dec_ix_ready;
  logic [2:0]    dec_ix_op_type;
  logic          dec_ix_wb_en, dec_ix_rs1_used, dec_ix_rs2_used;
  logic [4:0]    dec_ix_rs1, dec_ix_rs2, dec_ix_rd;
  logic          ix_issue_valid, ix_issue_ready;
  logic          lsu_wb_valid, md_wb_valid;
  logic [4:0]    lsu_wb_rd, md_wb_rd;
  logic [CW-1:0] sb_outstanding;
  logic          sb_idle;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic       is_load;
    logic [4:0] wrd;
  } ent_t;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_flush      (pipe_flush),
    .dec_ix_valid    (dec_ix_valid),
    .dec_ix_ready    (dec_ix_ready),
    .dec_ix_op_type  (dec_ix_op_type),
    .dec_ix_wb_en    (dec_ix_wb_en),
    .dec_ix_rs1_used (dec_ix_rs1_used),
    .dec_ix_rs2_used (dec_ix_rs2_used),
    .dec_ix_rs1      (dec_ix_rs1),
    .dec_ix_rs2      (dec_ix_rs2),
    .dec_ix_rd       (dec_ix_rd),
    .ix_issue_valid  (ix_issue_valid),
    .ix_issue_ready  (ix_issue_ready),
    .lsu_wb_valid    (lsu_wb_valid),
    .lsu_wb_rd       (lsu_wb_rd),
    .md_wb_valid     (md_wb_valid),
    .md_wb_rd        (md_wb_rd),
    .sb_outstanding  (sb_outstanding),
    .sb_idle         (sb_idle)
  );

  task automatic drive_op(input logic v, input logic [2:0] t, input logic wb,
                          input logic u1, input logic u2,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    dec_ix_valid = v; dec_ix_op_type = t; dec_ix_wb_en = wb;
    dec_ix_rs1_used = u1; dec_ix_rs2_used = u2;
    dec_ix_rs1 = r1; dec_ix_rs2 = r2; dec_ix_rd = rd;
  endtask

  task automatic drive_wb(input logic lv, input logic [4:0] lr, input logic mv, input logic [4:0] mr);
    lsu_wb_valid = lv; lsu_wb_rd = lr; md_wb_valid = mv; md_wb_rd = mr;
  endtask

  task automatic idle_inputs();
    pipe_flush = 1'b0;
    ix_issue_ready = 1'b1;
    drive_op(1'b0, OT_INT, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_op(1'b1, OT_INT, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", dec_ix_ready); else pass_cnt++;
    tick();
    rst = 1'b0;
    idle_inputs();
    mid();
    total_cnt++; if (sb_outstanding !== 3'd0) $display("FAIL rst_outstanding: got %0d want 0", sb_outstanding); else pass_cnt++;
    total_cnt++; if (sb_idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", sb_idle); else pass_cnt++;
    total_cnt++; if (dec_ix_ready !== 1'b1) $display("FAIL rst_empty_ready: got %b want 1", dec_ix_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_raw_bypass();
    do_reset();
    drive_op(1'b1, OT_LOAD, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL raw_load_issue: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    drive_op(1'b1, OT_INT, 1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd6);
    mid();
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL raw_stall_ready: got %b want 0", dec_ix_ready); else pass_cnt++;
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL raw_stall_valid: got %b want 0", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (sb_outstanding !== 3'd1) $display("FAIL raw_cnt1: got %0d want 1", sb_outstanding); else pass_cnt++;
    tick();
    drive_wb(1'b1, 5'd5, 1'b0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL raw_bypass_valid: got %b want 1", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (dec_ix_ready !== 1'b1) $display("FAIL raw_bypass_ready: got %b want 1", dec_ix_ready); else pass_cnt++;
    tick();
    idle_inputs();
    mid();
    total_cnt++; if (sb_outstanding !== 3'd0) $display("FAIL raw_cnt0: got %0d want 0", sb_outstanding); else pass_cnt++;
    total_cnt++; if (sb_idle !== 1'b1) $display("FAIL raw_idle: got %b want 1", sb_idle); else pass_cnt++;
    tick();
  endtask

  task automatic test_waw();
    do_reset();
    drive_op(1'b1, OT_MULDIV, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL waw_mul_issue: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    drive_op(1'b1, OT_LOAD, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7);
    mid();
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL waw_stall: got %b want 0", dec_ix_ready); else pass_cnt++;
    tick();
    drive_wb(1'b0, 5'd0, 1'b1, 5'd7);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL waw_release: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
    drive_op(1'b1, OT_INT, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd9);
    mid();
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL waw_set_wins: got %b want 0", dec_ix_ready); else pass_cnt++;
    total_cnt++; if (sb_outstanding !== 3'd1) $display("FAIL waw_net_cnt: got %0d want 1", sb_outstanding); else pass_cnt++;
    tick();
    drive_wb(1'b1, 5'd7, 1'b0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL waw_dep_issue: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    idle_inputs();
    mid();
    total_cnt++; if (sb_outstanding !== 3'd0) $display("FAIL waw_cnt0: got %0d want 0", sb_outstanding); else pass_cnt++;
    tick();
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_op(1'b1, OT_LOAD, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'(i));
      mid();
      total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL max_fill_%0d: got %b want 1", i, ix_issue_valid); else pass_cnt++;
      tick();
    end
    drive_op(1'b1, OT_LOAD, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
    mid();
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL max_stall: got %b want 0", dec_ix_ready); else pass_cnt++;
    total_cnt++; if (sb_outstanding !== 3'd4) $display("FAIL max_cnt4: got %0d want 4", sb_outstanding); else pass_cnt++;
    tick();
    drive_wb(1'b1, 5'd1, 1'b0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL max_release: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    idle_inputs();
    mid();
    total_cnt++; if (sb_outstanding !== 3'd4) $display("FAIL max_cnt_hold: got %0d want 4", sb_outstanding); else pass_cnt++;
    tick();
    drive_wb(1'b1, 5'd2, 1'b1, 5'd3);
    tick();
    drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
    mid();
    total_cnt++; if (sb_outstanding !== 3'd2) $display("FAIL max_dual_wb: got %0d want 2", sb_outstanding); else pass_cnt++;
    tick();
  endtask

  task automatic test_csr_drain();
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      drive_op(1'b1, OT_LOAD, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'(i));
      tick();
    end
    drive_op(1'b1, OT_CSR, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL csr_hold_valid: got %b want 0", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (sb_outstanding !== 3'd2) $display("FAIL csr_cnt2: got %0d want 2", sb_outstanding); else pass_cnt++;
    tick();
    drive_wb(1'b1, 5'd1, 1'b0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL csr_drain1: got %b want 0", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (sb_idle !== 1'b0) $display("FAIL csr_drain_idle: got %b want 0", sb_idle); else pass_cnt++;
    tick();
    drive_wb(1'b0, 5'd0, 1'b1, 5'd2);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL csr_drain2: got %b want 0", ix_issue_valid); else pass_cnt++;
    tick();
    drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL csr_issue: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    drive_op(1'b1, OT_INT, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd11);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL csr_post_bubble: got %b want 0", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL csr_post_ready: got %b want 0", dec_ix_ready); else pass_cnt++;
    tick();
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL csr_next_alu: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    drive_op(1'b1, OT_LOAD, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL x0_load_issue: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    drive_op(1'b1, OT_INT, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL x0_no_stall: got %b want 1", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (sb_outstanding !== 3'd1) $display("FAIL x0_cnt1: got %0d want 1", sb_outstanding); else pass_cnt++;
    total_cnt++; if (sb_idle !== 1'b0) $display("FAIL x0_idle: got %b want 0", sb_idle); else pass_cnt++;
    tick();
    idle_inputs();
    drive_wb(1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
    mid();
    total_cnt++; if (sb_outstanding !== 3'd0) $display("FAIL x0_cnt0: got %0d want 0", sb_outstanding); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush_reset();
    do_reset();
    drive_op(1'b1, OT_LOAD, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3);
    tick();
    drive_op(1'b1, OT_FENCE, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    pipe_flush = 1'b1;
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ix_issue_valid); else pass_cnt++;
    tick();
    pipe_flush = 1'b0;
    drive_op(1'b1, OT_INT, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
    mid();
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL flush_back_run: got %b want 1", ix_issue_valid); else pass_cnt++;
    total_cnt++; if (sb_outstanding !== 3'd1) $display("FAIL flush_cnt_kept: got %0d want 1", sb_outstanding); else pass_cnt++;
    tick();
    drive_op(1'b1, OT_INT, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd9);
    mid();
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL flush_busy_kept: got %b want 0", dec_ix_ready); else pass_cnt++;
    tick();
    rst = 1'b1;
    mid();
    total_cnt++; if (dec_ix_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", dec_ix_ready); else pass_cnt++;
    tick();
    rst = 1'b0;
    mid();
    total_cnt++; if (sb_idle !== 1'b1) $display("FAIL midrst_idle: got %b want 1", sb_idle); else pass_cnt++;
    total_cnt++; if (ix_issue_valid !== 1'b1) $display("FAIL midrst_busy_clr: got %b want 1", ix_issue_valid); else pass_cnt++;
    tick();
    drive_op(1'b0, OT_INT, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drive_wb(1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    idle_inputs();
    mid();
    total_cnt++; if (sb_outstanding !== 3'd0) $display("FAIL late_wb_sat: got %0d want 0", sb_outstanding); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    ent_t pend[$];
    ent_t effq[$];
    bit drain_m, bubble_m;
    do_reset();
    pend.delete();
    drain_m = 1'b0; bubble_m = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int loads[$], mds[$];
      int li, mi, ec;
      logic v, wb, u1, u2, rdy, fl;
      logic [2:0] t;
      logic [4:0] r1, r2, rd;
      logic [31:0] bm;
      bit lng, ser, haz, can, exp_v, exp_r, fire;
      v = ($urandom_range(0, 3) != 0);
      t = 3'($urandom_range(0, 6));
      wb = ($urandom_range(0, 3) != 0);
      u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
      r1 = 5'($urandom_range(0, 5)); r2 = 5'($urandom_range(0, 5)); rd = 5'($urandom_range(0, 5));
      rdy = ($urandom_range(0, 4) != 0);
      fl = ($urandom_range(0, 24) == 0);
      foreach (pend[k]) if (pend[k].is_load) loads.push_back(k); else mds.push_back(k);
      li = (loads.size() > 0 && $urandom_range(0, 2) == 0) ? loads[$urandom_range(0, loads.size() - 1)] : -1;
      mi = (mds.size() > 0 && $urandom_range(0, 2) == 0) ? mds[$urandom_range(0, mds.size() - 1)] : -1;
      drive_op(v, t, wb, u1, u2, r1, r2, rd);
      drive_wb(li >= 0, li >= 0 ? pend[li].wrd : 5'd0, mi >= 0, mi >= 0 ? pend[mi].wrd : 5'd0);
      ix_issue_ready = rdy; pipe_flush = fl;

      effq = pend;
      if (li > mi) begin effq.delete(li); if (mi >= 0) effq.delete(mi); end
      else if (mi >= 0) begin effq.delete(mi); if (li >= 0) effq.delete(li); end
      bm = '0;
      foreach (effq[k]) if (effq[k].wrd != 5'd0) bm[effq[k].wrd] = 1'b1;
      ec = effq.size();
      lng = (t == OT_LOAD) || (t == OT_MULDIV);
      ser = (t == OT_CSR) || (t == OT_FENCE);
      haz = (u1 && bm[r1]) || (u2 && bm[r2]) || (wb && rd != 0 && bm[rd]) || (lng && ec == MAXO);
      can = !drain_m && !bubble_m && !haz && (!ser || ec == 0);
      exp_v = v && can && !fl;
      exp_r = rdy && (can || !v);
      fire = exp_v && rdy;

      mid();
      total_cnt++; if (ix_issue_valid !== exp_v) $display("FAIL rnd_valid c%0d: got %b want %b", cyc, ix_issue_valid, exp_v); else pass_cnt++;
      total_cnt++; if (dec_ix_ready !== exp_r) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, dec_ix_ready, exp_r); else pass_cnt++;
      total_cnt++; if (sb_outstanding !== CW'(pend.size())) $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, sb_outstanding, pend.size()); else pass_cnt++;
      total_cnt++; if (sb_idle !== (pend.size() == 0 && !drain_m && !bubble_m)) $display("FAIL rnd_idle c%0d: got %b want %b", cyc, sb_idle, (pend.size() == 0 && !drain_m && !bubble_m)); else pass_cnt++;
      tick();

      pend = effq;
      if (fire && lng) pend.push_back('{is_load: (t == OT_LOAD), wrd: (wb ? rd : 5'd0)});
      if (fl)            begin drain_m = 1'b0; bubble_m = 1'b0; end
      else if (bubble_m) bubble_m = 1'b0;
      else if (drain_m)  drain_m = (ec != 0);
      else if (fire && ser) bubble_m = 1'b1;
      else if (v && ser && ec != 0) drain_m = 1'b1;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_raw_bypass();
    test_waw();
    test_max_outstanding();
    test_csr_drain();
    test_x0();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
